// File: rtl/kmeans_centroid_accumulator_if.sv
// Point-in / result-out handshake bundle for the k-means centroid accumulator.
// Carries the accept path, clear/drain control and the drained bin results.
interface kmeans_centroid_accumulator_if #(
  parameter int CW = 2,
  parameter int NW = 16
);
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_cluster;
  logic [31:0]   in_x;
  logic [31:0]   in_y;
  logic          clear;
  logic          drain_start;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_cluster;
  logic [31:0]   out_sum_x;
  logic [31:0]   out_sum_y;
  logic [NW-1:0] out_count;
  logic          out_ovf;
  logic          busy;

  modport slave (
    input  in_valid, in_cluster, in_x, in_y, clear, drain_start, out_ready,
    output in_ready, out_valid, out_cluster, out_sum_x, out_sum_y, out_count, out_ovf, busy
  );

  modport master (
    output in_valid, in_cluster, in_x, in_y, clear, drain_start, out_ready,
    input  in_ready, out_valid, out_cluster, out_sum_x, out_sum_y, out_count, out_ovf, busy
  );
endinterface

// File: rtl/kmeans_centroid_accumulator.sv
// Per-cluster X/Y sum and point-count accumulator for k-means centroid updates.
// Accumulates points in ACC, streams one beat per bin in DRAIN, clears in FLUSH.
module kmeans_centroid_accumulator #(
  parameter int K  = 4,
  parameter int CW = 2,
  parameter int NW = 16
) (
  input  logic clk,
  input  logic reset,
  kmeans_centroid_accumulator_if.slave bus
);

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [31:0]   sum_x_q [K];
  logic [31:0]   sum_y_q [K];
  logic [NW-1:0] cnt_q   [K];
  logic [K-1:0]  ovf_q;

  logic in_ready_s;
  logic out_valid_s;
  logic busy_s;
  logic accept_s;
  logic zero_bins_s;

  // Next-state, drain index and handshake decode
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    busy_s      = 1'b1;
    case (state_q)
      ST_ACC: begin
        busy_s     = 1'b0;
        in_ready_s = !bus.clear;
        if (bus.drain_start) begin
          state_d = ST_DRAIN;
          idx_d   = '0;
        end else begin
          state_d = ST_ACC;
        end
      end
      ST_DRAIN: begin
        out_valid_s = 1'b1;
        if (bus.out_ready) begin
          if (idx_q == CW'(K - 1)) begin
            state_d = ST_FLUSH;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + CW'(1);
          end
        end else begin
          idx_d = idx_q;
        end
      end
      ST_FLUSH: begin
        state_d = ST_ACC;
      end
      default: begin
        state_d = ST_ACC;
        idx_d   = '0;
      end
    endcase
  end

  // State and drain index registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_ACC;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign accept_s    = bus.in_valid && in_ready_s;
  assign zero_bins_s = ((state_q == ST_ACC) && bus.clear) || (state_q == ST_FLUSH);

  // Bin storage; an out-of-range cluster index matches no bin and is dropped
  always_ff @(posedge clk) begin
    if (reset || zero_bins_s) begin
      for (int k = 0; k < K; k++) begin
        sum_x_q[k] <= '0;
        sum_y_q[k] <= '0;
        cnt_q[k]   <= '0;
        ovf_q[k]   <= 1'b0;
      end
    end else begin
      for (int k = 0; k < K; k++) begin
        if (accept_s && (bus.in_cluster == CW'(k))) begin
          sum_x_q[k] <= sum_x_q[k] + bus.in_x;
          sum_y_q[k] <= sum_y_q[k] + bus.in_y;
          if (cnt_q[k] == {NW{1'b1}}) begin
            ovf_q[k] <= 1'b1;
          end else begin
            cnt_q[k] <= cnt_q[k] + NW'(1);
          end
        end
      end
    end
  end

  // Result beat mux, forced to zero outside DRAIN
  always_comb begin
    bus.out_cluster = '0;
    bus.out_sum_x   = '0;
    bus.out_sum_y   = '0;
    bus.out_count   = '0;
    bus.out_ovf     = 1'b0;
    if (out_valid_s) begin
      bus.out_cluster = idx_q;
      bus.out_sum_x   = sum_x_q[idx_q];
      bus.out_sum_y   = sum_y_q[idx_q];
      bus.out_count   = cnt_q[idx_q];
      bus.out_ovf     = ovf_q[idx_q];
    end else begin
      bus.out_cluster = '0;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.busy      = busy_s;

endmodule

// File: tb/tb_kmeans_centroid_accumulator.sv
// Randomized self-checking bench for kmeans_centroid_accumulator against a
// bin-array reference model; a second NW=4 instance exercises count saturation.
module tb_kmeans_centroid_accumulator;

  localparam int K = 4;

  logic clk = 1'b0;
  logic reset;

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  kmeans_centroid_accumulator_if #(.CW(2), .NW(16)) b  ();
  kmeans_centroid_accumulator_if #(.CW(2), .NW(4))  b2 ();

  kmeans_centroid_accumulator #(.K(K), .CW(2), .NW(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b)
  );

  kmeans_centroid_accumulator #(.K(K), .CW(2), .NW(4)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (b2)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mx [K];
  logic [31:0] my [K];
  int          mc [K];

  function automatic void model_zero();
    for (int k = 0; k < K; k++) begin
      mx[k] = 32'd0;
      my[k] = 32'd0;
      mc[k] = 0;
    end
  endfunction

  function automatic void model_add(input int c, input logic [31:0] x, input logic [31:0] y);
    if (c < K) begin
      mx[c] = mx[c] + x;
      my[c] = my[c] + y;
      mc[c] = mc[c] + 1;
    end
  endfunction

  task automatic idle_inputs();
    b.in_valid = 1'b0; b.in_cluster = 2'd0; b.in_x = 32'd0; b.in_y = 32'd0;
    b.clear = 1'b0; b.drain_start = 1'b0; b.out_ready = 1'b0;
    b2.in_valid = 1'b0; b2.in_cluster = 2'd0; b2.in_x = 32'd0; b2.in_y = 32'd0;
    b2.clear = 1'b0; b2.drain_start = 1'b0; b2.out_ready = 1'b0;
  endtask

  task automatic send(input int c, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    b.in_valid = 1'b1; b.in_cluster = 2'(c); b.in_x = x; b.in_y = y;
    b.clear = 1'b0; b.drain_start = 1'b0; b.out_ready = 1'b0;
    #1;
    n_cmp++;
    if (b.in_ready !== 1'b1) begin
      n_err++; $display("FAIL send_in_ready: got %b want 1", b.in_ready);
    end
    model_add(c, x, y);
  endtask

  task automatic drain_check(input bit with_clear, input bit with_pt, input int pc,
                             input logic [31:0] px, input logic [31:0] py,
                             input bit rnd, input int stall_beat, input int stall_len);
    int          stalls;
    bit          done;
    logic        rdy;
    logic [15:0] exp_cnt;
    logic        exp_ovf;
    @(negedge clk);
    b.drain_start = 1'b1; b.clear = with_clear; b.in_valid = with_pt;
    b.in_cluster = 2'(pc); b.in_x = px; b.in_y = py; b.out_ready = 1'b0;
    #1;
    n_cmp++;
    if (b.busy !== 1'b0 || b.in_ready !== !with_clear) begin
      n_err++; $display("FAIL drain_start_acc: busy=%b in_ready=%b want 0/%b", b.busy, b.in_ready, !with_clear);
    end
    if (with_clear) model_zero();
    else if (with_pt) model_add(pc, px, py);
    for (int i = 0; i < K; i++) begin
      stalls = 0;
      done   = 1'b0;
      while (!done) begin
        @(negedge clk);
        b.in_valid    = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        b.drain_start = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        b.clear       = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        if (i == stall_beat && stalls < stall_len) rdy = 1'b0;
        else if (rnd && stalls < 6) rdy = 1'($urandom_range(0, 1));
        else rdy = 1'b1;
        b.out_ready = rdy;
        #1;
        exp_cnt = (mc[i] > 65535) ? 16'hFFFF : 16'(mc[i]);
        exp_ovf = (mc[i] > 65535);
        n_cmp++;
        if (b.out_valid !== 1'b1 || b.busy !== 1'b1 || b.in_ready !== 1'b0) begin
          n_err++; $display("FAIL drain_flags beat%0d: valid=%b busy=%b in_ready=%b want 1/1/0", i, b.out_valid, b.busy, b.in_ready);
        end
        n_cmp++;
        if (b.out_cluster !== 2'(i)) begin
          n_err++; $display("FAIL drain_cluster: got %0d want %0d", b.out_cluster, i);
        end
        n_cmp++;
        if (b.out_sum_x !== mx[i] || b.out_sum_y !== my[i]) begin
          n_err++; $display("FAIL drain_sums bin%0d: got %h/%h want %h/%h", i, b.out_sum_x, b.out_sum_y, mx[i], my[i]);
        end
        n_cmp++;
        if (b.out_count !== exp_cnt || b.out_ovf !== exp_ovf) begin
          n_err++; $display("FAIL drain_count bin%0d: got %0d/%b want %0d/%b", i, b.out_count, b.out_ovf, exp_cnt, exp_ovf);
        end
        if (rdy) done = 1'b1;
        else stalls++;
      end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    n_cmp++;
    if (b.out_valid !== 1'b0 || b.busy !== 1'b1 || b.out_sum_x !== 32'd0 || b.out_count !== 16'd0) begin
      n_err++; $display("FAIL flush_state: valid=%b busy=%b sx=%h cnt=%0d want 0/1/0/0", b.out_valid, b.busy, b.out_sum_x, b.out_count);
    end
    model_zero();
    @(negedge clk);
    #1;
    n_cmp++;
    if (b.busy !== 1'b0 || b.in_ready !== 1'b1 || b.out_valid !== 1'b0) begin
      n_err++; $display("FAIL back_to_acc: busy=%b in_ready=%b valid=%b want 0/1/0", b.busy, b.in_ready, b.out_valid);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    model_zero();
    @(negedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (b.out_valid !== 1'b0 || b.busy !== 1'b0 || b.in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_hold: valid=%b busy=%b in_ready=%b want 0/0/1", b.out_valid, b.busy, b.in_ready);
    end
    reset = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++;
    if (b.out_valid !== 1'b0 || b.busy !== 1'b0 || b.in_ready !== 1'b1 || b.out_sum_x !== 32'd0) begin
      n_err++; $display("FAIL reset_after: valid=%b busy=%b in_ready=%b sx=%h", b.out_valid, b.busy, b.in_ready, b.out_sum_x);
    end
  endtask

  task automatic test_directed_drain();
    send(0, 32'd10, 32'd20);
    send(0, 32'd5, 32'hFFFF_FFFD);
    send(1, 32'd7, 32'd7);
    drain_check(1'b0, 1'b0, 0, 32'd0, 32'd0, 1'b0, -1, 0);
  endtask

  task automatic test_wrap();
    send(0, 32'hFFFF_FFF0, 32'd1);
    send(0, 32'h0000_0020, 32'd2);
    drain_check(1'b0, 1'b0, 0, 32'd0, 32'd0, 1'b0, -1, 0);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < K; k++) send(k, $urandom, $urandom);
    drain_check(1'b0, 1'b1, 3, $urandom, $urandom, 1'b0, 1, 5);
  endtask

  task automatic test_clear();
    send(2, 32'd100, 32'd200);
    send(3, 32'd1, 32'd2);
    @(negedge clk);
    b.in_valid = 1'b1; b.clear = 1'b1; b.in_cluster = 2'd1; b.in_x = 32'd9; b.in_y = 32'd9;
    #1;
    n_cmp++;
    if (b.in_ready !== 1'b0) begin
      n_err++; $display("FAIL clear_in_ready: got %b want 0", b.in_ready);
    end
    model_zero();
    drain_check(1'b0, 1'b0, 0, 32'd0, 32'd0, 1'b0, -1, 0);
    send(0, 32'd4, 32'd4);
    send(1, 32'd8, 32'd8);
    drain_check(1'b1, 1'b1, 2, 32'd77, 32'd77, 1'b0, -1, 0);
  endtask

  task automatic test_random();
    int r;
    for (int round = 0; round < 3; round++) begin
      for (int n = 0; n < 30; n++) begin
        r = $urandom_range(0, 19);
        if (r == 0) begin
          @(negedge clk);
          b.in_valid = 1'b1; b.clear = 1'b1; b.in_cluster = 2'($urandom_range(0, 3));
          b.in_x = $urandom; b.in_y = $urandom;
          #1;
          n_cmp++;
          if (b.in_ready !== 1'b0) begin
            n_err++; $display("FAIL rand_clear_ready: got %b want 0", b.in_ready);
          end
          model_zero();
        end else if (r < 5) begin
          @(negedge clk);
          idle_inputs();
        end else begin
          send($urandom_range(0, 3), $urandom, $urandom);
        end
      end
      drain_check(1'b0, 1'b1, $urandom_range(0, 3), $urandom, $urandom, 1'b1, -1, 0);
    end
  endtask

  task automatic test_saturation();
    logic [31:0] sx;
    logic [31:0] sy;
    logic [31:0] xv;
    logic [31:0] yv;
    sx = 32'd0;
    sy = 32'd0;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      xv = $urandom; yv = $urandom;
      b2.in_valid = 1'b1; b2.in_cluster = 2'd2; b2.in_x = xv; b2.in_y = yv;
      sx = sx + xv; sy = sy + yv;
    end
    @(negedge clk);
    b2.in_valid = 1'b0; b2.drain_start = 1'b1;
    for (int i = 0; i < K; i++) begin
      @(negedge clk);
      b2.drain_start = 1'b0; b2.out_ready = 1'b1;
      #1;
      n_cmp++;
      if (b2.out_valid !== 1'b1 || b2.out_cluster !== 2'(i)) begin
        n_err++; $display("FAIL sat_beat: valid=%b cluster=%0d want 1/%0d", b2.out_valid, b2.out_cluster, i);
      end
      n_cmp++;
      if (b2.out_count !== ((i == 2) ? 4'd15 : 4'd0) || b2.out_ovf !== (i == 2)) begin
        n_err++; $display("FAIL sat_count bin%0d: got %0d/%b want %0d/%b", i, b2.out_count, b2.out_ovf, (i == 2) ? 15 : 0, (i == 2));
      end
      n_cmp++;
      if (b2.out_sum_x !== ((i == 2) ? sx : 32'd0) || b2.out_sum_y !== ((i == 2) ? sy : 32'd0)) begin
        n_err++; $display("FAIL sat_sums bin%0d: got %h/%h want %h/%h", i, b2.out_sum_x, b2.out_sum_y, (i == 2) ? sx : 32'd0, (i == 2) ? sy : 32'd0);
      end
    end
    @(negedge clk);
    b2.out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_drain();
    send(0, 32'd3, 32'd4);
    send(2, 32'd5, 32'd6);
    @(negedge clk);
    idle_inputs();
    b.drain_start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      b.drain_start = 1'b0; b.out_ready = 1'b1;
    end
    @(negedge clk);
    b.out_ready = 1'b1; reset = 1'b1;
    #1;
    n_cmp++;
    if (b.out_valid !== 1'b1 || b.out_cluster !== 2'd2 || b.out_sum_x !== 32'd5) begin
      n_err++; $display("FAIL mid_drain_beat2: valid=%b cluster=%0d sx=%h want 1/2/5", b.out_valid, b.out_cluster, b.out_sum_x);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if (b.out_valid !== 1'b0 || b.busy !== 1'b0 || b.in_ready !== 1'b1) begin
      n_err++; $display("FAIL mid_drain_abort: valid=%b busy=%b in_ready=%b want 0/0/1", b.out_valid, b.busy, b.in_ready);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (b.out_valid !== 1'b0 || b.busy !== 1'b0) begin
      n_err++; $display("FAIL mid_drain_no_beats: valid=%b busy=%b want 0/0", b.out_valid, b.busy);
    end
    model_zero();
    drain_check(1'b0, 1'b0, 0, 32'd0, 32'd0, 1'b0, -1, 0);
  endtask

  initial begin
    test_reset();
    test_directed_drain();
    test_wrap();
    test_back_to_back();
    test_clear();
    test_random();
    test_saturation();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
